// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the 32x32 register file: buffers execute results, drains one per
// cycle into the regfile write port and forwards pending values to decode. Option: WBQ_BYPASS_EN.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          InValid,
  input  logic [4:0]    InReg,
  input  logic [31:0]   InData,
  output logic          InReady,
  input  logic          DrainEn,
  output logic [4:0]    WriteRegister,
  output logic [31:0]   WriteData,
  output logic          RegWrite,
  input  logic [4:0]    ReadRegister1,
  input  logic [4:0]    ReadRegister2,
  input  logic [31:0]   ReadData1,
  input  logic [31:0]   ReadData2,
  output logic [31:0]   FwdData1,
  output logic [31:0]   FwdData2,
  output logic [AW:0]   Level
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, accept, push, pop, bypass;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign InReady = Rst_n && !full;
  assign accept  = InValid && InReady;
  assign pop     = !empty && DrainEn;

`ifdef WBQ_BYPASS_EN
  // Empty queue and open write port: hand the write straight to the regfile.
  assign bypass = Rst_n && empty && DrainEn && InValid && (InReg != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Writes to r0 complete the handshake but are discarded.
  assign push     = accept && (InReg != 5'd0) && !bypass;
  assign RegWrite = pop || bypass;
  assign Level    = count_q;
  assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    WriteRegister = 5'd0;
    WriteData     = 32'd0;
    if (bypass) begin
      WriteRegister = InReg;
      WriteData     = InData;
    end else if (Rst_n) begin
      WriteRegister = mem_q[head_q].rd;
      WriteData     = mem_q[head_q].data;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [AW-1:0] idx;
    FwdData1 = ReadData1;
    FwdData2 = ReadData2;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((AW+1)'(i) < count_q) begin
        if (ReadRegister1 != 5'd0 && mem_q[idx].rd == ReadRegister1) FwdData1 = mem_q[idx].data;
        if (ReadRegister2 != 5'd0 && mem_q[idx].rd == ReadRegister2) FwdData2 = mem_q[idx].data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + AW'(1);
      if (pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[tail_q] <= '{rd: InReg, data: InData};
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus randomized traffic,
// all checked against a queue-based model of pending writes.
module tb_regfile_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          InValid, InReady, DrainEn, RegWrite;
  logic [4:0]    InReg, WriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0]   InData, WriteData, ReadData1, ReadData2, FwdData1, FwdData2;
  logic [AW:0]   Level;

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReg(InReg), .InData(InData),
    .InReady(InReady), .DrainEn(DrainEn), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .RegWrite(RegWrite), .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .FwdData1(FwdData1), .FwdData2(FwdData2), .Level(Level)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rr, input logic [31:0] raw);
    if (rr == 5'd0) return raw;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == rr) return q[i].data;
    return raw;
  endfunction

  function automatic bit is_bypass();
`ifdef WBQ_BYPASS_EN
    return Rst_n && q.size() == 0 && DrainEn && InValid && InReg != 5'd0;
`else
    return 1'b0;
`endif
  endfunction

  // Checks every output against the model for the current inputs.
  task automatic compare();
    bit          exp_rw;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    exp_rw = 1'b0;
    exp_wr = 5'd0;
    exp_wd = 32'd0;
    if (is_bypass()) begin
      exp_rw = 1'b1; exp_wr = InReg; exp_wd = InData;
    end else if (Rst_n && q.size() != 0 && DrainEn) begin
      exp_rw = 1'b1; exp_wr = q[0].rd; exp_wd = q[0].data;
    end
    chk("InReady", 32'(InReady), 32'(Rst_n && q.size() < DEPTH));
    chk("Level", 32'(Level), 32'(q.size()));
    chk("RegWrite", 32'(RegWrite), 32'(exp_rw));
    if (exp_rw || !Rst_n) begin
      chk("WriteRegister", 32'(WriteRegister), 32'(exp_wr));
      chk("WriteData", WriteData, exp_wd);
    end
    chk("FwdData1", FwdData1, fwd(ReadRegister1, ReadData1));
    chk("FwdData2", FwdData2, fwd(ReadRegister2, ReadData2));
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge.
  task automatic step();
    bit pop, push;
    #1;
    compare();
    pop  = Rst_n && q.size() != 0 && DrainEn;
    push = Rst_n && InValid && q.size() < DEPTH && InReg != 5'd0 && !is_bypass();
    @(posedge Clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{rd: InReg, data: InData});
    @(negedge Clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d);
    InValid = v; InReg = r; InData = d;
  endtask

  initial begin
    Rst_n = 1'b0; DrainEn = 1'b0; drive(1'b0, 5'd0, 32'd0);
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; ReadData1 = 32'd0; ReadData2 = 32'd0;

    // Reset held for two cycles
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_inready", 32'(InReady), 32'd0);
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    Rst_n = 1'b1;
    ReadRegister1 = 5'd9; ReadData1 = 32'h1234;
    #1;
    chk("post_rst_inready", 32'(InReady), 32'd1);
    chk("post_rst_fwd1", FwdData1, 32'h1234);
    @(negedge Clk);

    // Single write
    DrainEn = 1'b1; drive(1'b1, 5'd2, 32'd42);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("single_regwrite", 32'(RegWrite), 32'd1);
    chk("single_wreg", 32'(WriteRegister), 32'd2);
    chk("single_wdata", WriteData, 32'd42);
    chk("single_level", 32'(Level), 32'd1);
    step();
    #1;
    chk("single_level_after", 32'(Level), 32'd0);
    @(negedge Clk);

    // Fill while stalled, then drain in order
    DrainEn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(3 + k), 32'(10 + k));
      step();
    end
    drive(1'b1, 5'd7, 32'd99);
    #1;
    chk("full_level", 32'(Level), 32'd4);
    chk("full_inready", 32'(InReady), 32'd0);
    chk("full_regwrite", 32'(RegWrite), 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0);
    DrainEn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_wreg", 32'(WriteRegister), 32'(3 + k));
      chk("drain_wdata", WriteData, 32'(10 + k));
      step();
      if (k == 0) begin
        #1;
        chk("drain_inready", 32'(InReady), 32'd1);
      end
    end

    // Youngest matching entry is forwarded
    DrainEn = 1'b0;
    drive(1'b1, 5'd2, 32'd15); step();
    drive(1'b1, 5'd2, 32'd10); step();
    drive(1'b0, 5'd0, 32'd0);
    ReadRegister1 = 5'd2; ReadRegister2 = 5'd2; ReadData1 = 32'd7; ReadData2 = 32'd7;
    #1;
    chk("fwd_young1", FwdData1, 32'd10);
    chk("fwd_young2", FwdData2, 32'd10);
    step();
    DrainEn = 1'b1;
    repeat (2) step();

    // Register 0 write is dropped
    drive(1'b1, 5'd0, 32'd10);
    ReadRegister1 = 5'd0; ReadData1 = 32'd0;
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("r0_level", 32'(Level), 32'd0);
    chk("r0_regwrite", 32'(RegWrite), 32'd0);
    chk("r0_fwd1", FwdData1, 32'd0);
    step();

    // Reset with three entries pending
    DrainEn = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'(k), 32'(100 + k));
      step();
    end
    drive(1'b0, 5'd0, 32'd0);
    DrainEn = 1'b1;
    #2;
    Rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_regwrite", 32'(RegWrite), 32'd0);
    chk("midrst_level", 32'(Level), 32'd0);
    chk("midrst_inready", 32'(InReady), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("midrst_nowrite", 32'(RegWrite), 32'd0);
      step();
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      DrainEn = $urandom_range(0, 9) < 6;
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      ReadData1 = $urandom;
      ReadData2 = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        Rst_n = 1'b0;
        q.delete();
        step();
        Rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
Write-back buffer that sits directly upstream of the 32x32 register file. It accepts result writes from the execute stage over a valid/ready handshake and queues them in a small FIFO. It drains one entry per cycle into the register file's single write port (WriteRegister/WriteData/RegWrite). It also forwards still-pending results onto both read ports, so decode always sees the newest value of a register.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
AW, 2, pointer width; equals log2(DEPTH)

Ports:
Clk  in  1  clock, positive-edge triggered
Rst_n  in  1  asynchronous active-low reset
InValid  in  1  execute stage presents a write
InReg  in  5  destination register of the incoming write
InData  in  32  incoming write data
InReady  out  1  queue can accept; transfer occurs when InValid && InReady at posedge Clk
DrainEn  in  1  permits draining; low holds the queue (regfile write port stalled)
WriteRegister  out  5  to regfile write address
WriteData  out  32  to regfile write data
RegWrite  out  1  to regfile write enable
ReadRegister1  in  5  decode read address 1; also driven to the regfile
ReadRegister2  in  5  decode read address 2; also driven to the regfile
ReadData1  in  32  raw regfile read data, port 1
ReadData2  in  32  raw regfile read data, port 2
FwdData1  out  32  forwarded read data, port 1
FwdData2  out  32  forwarded read data, port 2
Level  out  AW+1  number of valid entries (0..DEPTH)

Behaviour:
- Storage: circular FIFO of {reg[4:0], data[31:0]}; head pointer, tail pointer, count registers.
- Reset (Rst_n low, asynchronous): head=0, tail=0, count=0; entry contents are don't-care. While reset is asserted: InReady=0, RegWrite=0, WriteRegister=0, WriteData=0, Level=0.
- Reset mid-operation: all pending entries are discarded and nothing is written to the regfile. Outputs return to their reset values immediately, without waiting for a clock edge.
- Ready: InReady = Rst_n && (count != DEPTH). It is a function of registered state only, never of InValid. When full, an accept in the same cycle as a pop is not allowed.
- Enqueue: on accept, store {InReg, InData} at tail and increment tail (wraps modulo DEPTH).
- Register 0: an accepted write with InReg==0 completes the handshake but is not stored, and count does not change.
- Drain:
  - RegWrite = (count != 0) && DrainEn.
  - WriteRegister and WriteData show the head entry combinationally.
  - When RegWrite=1, head increments at the same posedge Clk at which the regfile samples the write.
- Latency (macro off): an accept at edge N makes RegWrite high in the cycle after edge N. If DrainEn=1, the regfile is updated at edge N+1.
- Simultaneous accept and pop: count is unchanged and both pointers advance.
- Forwarding, per port p:
  - If ReadRegisterp != 0, search all valid entries, head included, and take the youngest entry whose reg matches.
  - On a hit, FwdDatap = that entry's data; otherwise FwdDatap = ReadDatap.
  - ReadRegisterp == 0 always gives FwdDatap = ReadDatap (the regfile returns 0).
  - Forwarding is purely combinational.
  - An entry being accepted in the current cycle is not forwarded until the next cycle.
- Level = count, registered.

Optional Feature:
WBQ_BYPASS_EN
- Defined: when count==0, DrainEn=1, InValid=1 and InReg!=0, the incoming write goes straight to the write port in the same cycle, with zero latency:
  - RegWrite=1, WriteRegister=InReg, WriteData=InData.
  - Nothing is stored and count stays 0.
  - InReady is unchanged.
- Defined, InValid=1 and InReg==0 in that same situation: RegWrite stays 0 and the write is dropped, as in the queued path.
- Not defined: every write goes through the queue, with a minimum latency of one cycle as stated above.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles, then release -> InReady=1, RegWrite=0, Level=0, FwdData1=ReadData1.
- Single write: accept reg 2 = 42 with DrainEn=1 -> next cycle RegWrite=1, WriteRegister=2, WriteData=42, Level=1; the following cycle Level=0.
- Full/stall: DrainEn=0, accept 4 writes (regs 3, 4, 5, 6 = 10, 11, 12, 13) -> Level=4, InReady=0, a 5th InValid is not accepted, RegWrite=0. Raise DrainEn -> writes drain in order 3, 4, 5, 6 over 4 cycles, and InReady returns to 1 after the first pop.
- Forwarding youngest: DrainEn=0, queue reg 2 = 15 then reg 2 = 10, drive ReadRegister1=2, ReadRegister2=2, ReadData1=ReadData2=7 -> FwdData1=FwdData2=10.
- Register 0: accept reg 0 = 10 -> Level stays 0, RegWrite never asserts; with ReadRegister1=0 and ReadData1=0 -> FwdData1=0.
- Mid-operation reset: with 3 entries queued, pulse Rst_n low between edges -> RegWrite=0 immediately, Level=0, and no further regfile writes occur.
